ee357_4x32_demux_bank: RTL and testbench



---
 rtl/ee357_demux_pkg.sv | 21 ++
 rtl/ee357_slot_reg.sv | 55 +++++
 rtl/ee357_4x32_demux_bank.sv | 120 ++++++++++++
 tb/tb_ee357_4x32_demux_bank.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ee357_demux_pkg.sv
// Shared definitions for the 4x32 demultiplexing register bank.
// Provides the slot index constants, the select and mask types, the default
// data width, and a helper that turns a slot select into a one-hot mask.
package ee357_demux_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned NUM_SLOTS     = 4;

  typedef logic [1:0] slot_sel_t;
  typedef logic [3:0] slot_mask_t;

  localparam slot_sel_t SLOT_ZERO  = 2'd0;
  localparam slot_sel_t SLOT_ONE   = 2'd1;
  localparam slot_sel_t SLOT_TWO   = 2'd2;
  localparam slot_sel_t SLOT_THREE = 2'd3;

  function automatic slot_mask_t sel_to_mask(slot_sel_t sel);
    return slot_mask_t'(1) << sel;
  endfunction

endpackage

// File: rtl/ee357_slot_reg.sv
// One holding slot of the demux bank: a WIDTH-bit data register plus a full
// flag. A write loads the data and sets full; a consume without a write clears
// full while keeping the data. Write wins over consume (zero-bubble refill).
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset (clears data and full)
//   wr_en    load data this cycle
//   consume  consumer has read the slot
//   data     write data
//   q        slot contents
//   full     slot holds unconsumed data
module ee357_slot_reg
  import ee357_demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             consume,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic             full
);

  logic [WIDTH-1:0] data_q;
  logic             full_q;
  logic             full_d;

  always_comb begin
    full_d = full_q;
    if (wr_en) begin
      full_d = 1'b1;
    end else if (consume) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
      if (wr_en) begin
        data_q <= data;
      end
    end
  end

  assign q    = data_q;
  assign full = full_q;

endmodule

// File: rtl/ee357_4x32_demux_bank.sv
// 1-to-4 demultiplexing register bank. A single valid/ready producer stream is
// routed by in_sel into one of four slots; all slots are exposed in parallel
// with per-slot full flags, and per-slot consume pulses free them again.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_data    write data
//   in_sel     target slot (0..3)
//   in_valid   write request
//   in_ready   bank can accept a write to slot in_sel this cycle
//   consume    per-slot read-done pulses
//   out_zero .. out_three   slot contents
//   full       per-slot holds-unconsumed-data flags
//   wr_count   accepted writes, modulo 2^CNT_W
//   overflow   sticky overwrite-of-full-slot flag
//
// Build option EE357_DEMUX_OVERWRITE_EN: when defined, in_ready is always 1,
// writes to a full slot overwrite it, and overflow is set until reset. When
// undefined, full slots backpressure and overflow is tied to 0.
module ee357_4x32_demux_bank
  import ee357_demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       consume,
  output logic [WIDTH-1:0] out_zero,
  output logic [WIDTH-1:0] out_one,
  output logic [WIDTH-1:0] out_two,
  output logic [WIDTH-1:0] out_three,
  output logic [3:0]       full,
  output logic [CNT_W-1:0] wr_count,
  output logic             overflow
);

  slot_mask_t       full_vec;
  slot_mask_t       wr_mask;
  logic             accept;
  logic [WIDTH-1:0] slot_q [NUM_SLOTS];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

`ifdef EE357_DEMUX_OVERWRITE_EN
  assign in_ready = 1'b1;
`else
  // A same-cycle consume frees the slot in time for the refill.
  assign in_ready = !full_vec[in_sel] || consume[in_sel];
`endif

  assign accept  = in_valid && in_ready;
  assign wr_mask = accept ? sel_to_mask(in_sel) : '0;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    ee357_slot_reg #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_mask[i]),
      .consume (consume[i]),
      .data    (in_data),
      .q       (slot_q[i]),
      .full    (full_vec[i])
    );
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef EE357_DEMUX_OVERWRITE_EN
  logic ovf_q;
  logic ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (accept && full_vec[in_sel] && !consume[in_sel]) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign out_zero  = slot_q[SLOT_ZERO];
  assign out_one   = slot_q[SLOT_ONE];
  assign out_two   = slot_q[SLOT_TWO];
  assign out_three = slot_q[SLOT_THREE];
  assign full      = full_vec;
  assign wr_count  = cnt_q;

endmodule

// File: tb/tb_ee357_4x32_demux_bank.sv
// Scoreboard bench for ee357_4x32_demux_bank. The stimulus process pushes the
// expected bank state for every cycle that changes it; a monitor process pops
// and compares one cycle later, whenever the DUT accepts a write or a
// state-changing consume is issued.
module tb_ee357_4x32_demux_bank;

  typedef struct packed {
    logic [31:0] o0;
    logic [31:0] o1;
    logic [31:0] o2;
    logic [31:0] o3;
    logic [3:0]  full;
    logic [7:0]  cnt;
    logic        ovf;
  } snap_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  consume;
  logic [31:0] out_zero;
  logic [31:0] out_one;
  logic [31:0] out_two;
  logic [31:0] out_three;
  logic [3:0]  full;
  logic [7:0]  wr_count;
  logic        overflow;

  ee357_4x32_demux_bank #(
    .WIDTH (32),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .consume   (consume),
    .out_zero  (out_zero),
    .out_one   (out_one),
    .out_two   (out_two),
    .out_three (out_three),
    .full      (full),
    .wr_count  (wr_count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  snap_t exp_q [$];
  logic  snap_req = 1'b0;
  bit    stim_done = 1'b0;

  // Reference state, updated by the stimulus from the bank's rules.
  logic [31:0] m_slot [4];
  logic [3:0]  m_full;
  logic [7:0]  m_cnt;
  logic        m_ovf;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.o0 = m_slot[0]; s.o1 = m_slot[1]; s.o2 = m_slot[2]; s.o3 = m_slot[3];
    s.full = m_full; s.cnt = m_cnt; s.ovf = m_ovf;
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_slot[i] = '0;
    m_full = '0;
    m_cnt  = '0;
    m_ovf  = 1'b0;
  endtask

  // Drive one cycle at the falling edge; checks in_ready and queues the
  // expected state for the monitor.
  task automatic cycle(input logic v, input logic [1:0] sel, input logic [31:0] d,
                       input logic [3:0] cons);
    logic exp_rdy;
    logic acc;
    @(negedge clk);
    in_valid = v; in_sel = sel; in_data = d; consume = cons;
`ifdef EE357_DEMUX_OVERWRITE_EN
    exp_rdy = 1'b1;
`else
    exp_rdy = !m_full[sel] || cons[sel];
`endif
    #1;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc = v && exp_rdy;
    snap_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cons[i] && !(acc && sel == 2'(i))) m_full[i] = 1'b0;
    end
    if (acc) begin
      if (m_full[sel] && !cons[sel]) m_ovf = 1'b1;
      m_slot[sel] = d;
      m_full[sel] = 1'b1;
      m_cnt       = m_cnt + 8'd1;
      exp_q.push_back(model_snap());
    end else if (cons != 4'b0) begin
      snap_req = 1'b1;
      exp_q.push_back(model_snap());
    end
  endtask

  task automatic idle();
    cycle(1'b0, 2'd0, 32'h0, 4'b0000);
  endtask

  // Monitor: a handshake (or flagged consume) seen before the rising edge
  // means the next state must match the head of the queue.
  initial begin
    logic  trig;
    snap_t e;
    forever begin
      @(negedge clk);
      #3;
      trig = rst_n && ((in_valid && in_ready) || snap_req);
      @(posedge clk);
      #1;
      if (trig) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("out_zero",  64'(out_zero),  64'(e.o0));
          chk("out_one",   64'(out_one),   64'(e.o1));
          chk("out_two",   64'(out_two),   64'(e.o2));
          chk("out_three", 64'(out_three), 64'(e.o3));
          chk("full",      64'(full),      64'(e.full));
          chk("wr_count",  64'(wr_count),  64'(e.cnt));
          chk("overflow",  64'(overflow),  64'(e.ovf));
        end
      end
    end
  end

  initial begin
    model_reset();
    // Reset held low while a write is presented: nothing may load.
    rst_n = 1'b0; in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hDEAD_BEEF; consume = 4'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("rst_out_two", 64'(out_two), 64'(0));
      chk("rst_full", 64'(full), 64'(0));
      chk("rst_wr_count", 64'(wr_count), 64'(0));
      chk("rst_overflow", 64'(overflow), 64'(0));
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Fill all four slots back to back.
    cycle(1'b1, 2'd0, 32'h11, 4'b0000);
    cycle(1'b1, 2'd1, 32'h22, 4'b0000);
    cycle(1'b1, 2'd2, 32'h33, 4'b0000);
    cycle(1'b1, 2'd3, 32'h44, 4'b0000);
    idle();
    chk("fill_full", 64'(full), 64'(4'b1111));
    chk("fill_cnt", 64'(wr_count), 64'(4));
    chk("fill_out_three", 64'(out_three), 64'h44);

`ifndef EE357_DEMUX_OVERWRITE_EN
    // Backpressure on full slot 1, then a consume releases it on the same edge.
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 2'd1, 32'h55, 4'b0000);
      chk("bp_out_one", 64'(out_one), 64'h22);
    end
    cycle(1'b1, 2'd1, 32'h55, 4'b0010);
    idle();
    chk("refill_out_one", 64'(out_one), 64'h55);
    chk("refill_full", 64'(full), 64'(4'b1111));

    // Drain slots 1 and 3; data stays.
    cycle(1'b0, 2'd0, 32'h0, 4'b1010);
    idle();
    chk("drain_full", 64'(full), 64'(4'b0101));
    chk("drain_out_three", 64'(out_three), 64'h44);

    // 256 zero-bubble refills alternating slots 0 and 2 wrap the counter.
    for (int i = 0; i < 256; i++) begin
      logic [1:0] s;
      s = (i % 2 == 0) ? 2'd0 : 2'd2;
      cycle(1'b1, s, 32'h1000 + 32'(i), 4'(1) << s);
      if (i == 250) begin
        @(posedge clk); #1;
        chk("wrap_zero", 64'(wr_count), 64'(0));
      end
    end
    idle();
    chk("wrap_cnt", 64'(wr_count), 64'(5));
    // Consume of an empty slot is ignored.
    cycle(1'b0, 2'd0, 32'h0, 4'b0010);
    idle();
    chk("idle_consume_full", 64'(full), 64'(4'b0101));
`else
    // Overwrite of full slot 0 without consume sets sticky overflow.
    cycle(1'b1, 2'd0, 32'h66, 4'b0000);
    idle();
    chk("ovw_out_zero", 64'(out_zero), 64'h66);
    chk("ovw_overflow", 64'(overflow), 64'(1));
    cycle(1'b1, 2'd1, 32'h77, 4'b0010);
    idle();
    idle();
    chk("ovw_sticky", 64'(overflow), 64'(1));
`endif

    // Asynchronous reset mid-cycle clears everything without a clock edge.
    @(negedge clk);
    in_valid = 1'b1; in_sel = 2'd3; in_data = 32'hCAFE_F00D; consume = 4'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_zero", 64'(out_zero), 64'(0));
    chk("async_out_three", 64'(out_three), 64'(0));
    chk("async_full", 64'(full), 64'(0));
    chk("async_cnt", 64'(wr_count), 64'(0));
    chk("async_ovf", 64'(overflow), 64'(0));
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 2'd2, 32'h99, 4'b0000);
    idle();
    idle();
    stim_done = 1'b1;
  end

  initial begin
    fork
      begin
        wait (stim_done);
        repeat (3) @(posedge clk);
      end
      begin
        repeat (5000) @(posedge clk);
        chk("timeout", 64'(1), 64'(0));
      end
    join_any
    disable fork;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
